// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS sequencing controller: steps each instruction through fetch/decode/exec/mem/wb.
// Optional CONTROL_ADDI_EN: decode opcode 001000 as addi; otherwise it halts as illegal.
module control_multiciclo (
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic [5:0]  op,
   input  logic        zf,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        pcSrc,
   output logic        irWrite,
   output logic        wEnMemoria1,
   output logic        wEnMemoria2,
   output logic        rEnMemoria2,
   output logic        mux,
   output logic        registroInstruccion,
   output logic        aluSrc,
   output logic [2:0]  aluOp,
   output logic [2:0]  estado,
   output logic        illegal,
   output logic [15:0] retired
);
   // state  | meaning
   // IDLE   | after reset, one cycle before first fetch
   // FETCH  | load IR, PC <= PC+4
   // DECODE | latch opcode, pick path
   // EXEC   | ALU operation (R funct or base+imm)
   // MEM    | data RAM access, waits for memReady
   // WB     | register bank write
   // BRANCH | beq compare, PC <= target when zf
   // HALT   | unsupported opcode, wait for reset

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_BRANCH = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [2:0] {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_ILL} kind_t;

   function automatic kind_t classify(input logic [5:0] o);
      kind_t k;
      case (o)
         6'b000000: k = K_R;
         6'b100011: k = K_LW;
         6'b101011: k = K_SW;
         6'b000100: k = K_BEQ;
`ifdef CONTROL_ADDI_EN
         6'b001000: k = K_ADDI;
`endif
         default:   k = K_ILL;
      endcase
      return k;
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  opreg_q, opreg_d;
   logic [15:0] retired_q, retired_d;
   kind_t       kind_q, kind_d;

   logic pcw_q, pcsrc_q, irw_q, wen1_q, wen2_q, ren2_q, mux_q, rinst_q, alusrc_q, ill_q;
   logic pcw_d, pcsrc_d, irw_d, wen1_d, wen2_d, ren2_d, mux_d, rinst_d, alusrc_d, ill_d;
   logic [2:0] aluop_q, aluop_d;

   assign kind_q = classify(opreg_q);
   assign kind_d = classify(opreg_d);

   always_comb begin
      state_d   = state_q;
      opreg_d   = opreg_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            opreg_d = op;
            case (classify(op))
               K_R, K_LW, K_SW, K_ADDI: state_d = S_EXEC;
               K_BEQ:                   state_d = S_BRANCH;
               default:                 state_d = S_HALT;
            endcase
         end
         S_EXEC:   state_d = (kind_q == K_LW || kind_q == K_SW) ? S_MEM : S_WB;
         S_MEM: begin
            if (memReady) begin
               if (kind_q == K_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d   = S_FETCH;
                  retired_d = retired_q + 16'd1;
               end
            end
         end
         S_WB, S_BRANCH: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 16'd1;
         end
         default:  state_d = S_HALT;
      endcase
   end

   // Controls are computed for the state being entered so they register alongside it.
   always_comb begin
      pcw_d    = 1'b0;
      pcsrc_d  = 1'b0;
      irw_d    = 1'b0;
      wen1_d   = 1'b0;
      wen2_d   = 1'b0;
      ren2_d   = 1'b0;
      mux_d    = 1'b0;
      rinst_d  = 1'b0;
      alusrc_d = 1'b0;
      aluop_d  = 3'b000;
      ill_d    = 1'b0;
      case (state_d)
         S_FETCH: begin
            irw_d = 1'b1;
            pcw_d = 1'b1;
         end
         S_EXEC, S_MEM, S_WB: begin
            if (kind_d == K_R) begin
               aluop_d = 3'b010;
            end else begin
               alusrc_d = 1'b1;
            end
            if (state_d == S_MEM) begin
               ren2_d = (kind_d == K_LW);
               wen2_d = (kind_d == K_SW);
            end
            if (state_d == S_WB) begin
               wen1_d  = 1'b1;
               mux_d   = (kind_d == K_LW);
               rinst_d = (kind_d == K_R);
            end
         end
         S_BRANCH: begin
            aluop_d = 3'b001;
            pcsrc_d = 1'b1;
         end
         S_HALT:  ill_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q   <= S_IDLE;
         opreg_q   <= 6'd0;
         retired_q <= 16'd0;
         pcw_q     <= 1'b0;
         pcsrc_q   <= 1'b0;
         irw_q     <= 1'b0;
         wen1_q    <= 1'b0;
         wen2_q    <= 1'b0;
         ren2_q    <= 1'b0;
         mux_q     <= 1'b0;
         rinst_q   <= 1'b0;
         alusrc_q  <= 1'b0;
         aluop_q   <= 3'b000;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opreg_q   <= opreg_d;
         retired_q <= retired_d;
         pcw_q     <= pcw_d;
         pcsrc_q   <= pcsrc_d;
         irw_q     <= irw_d;
         wen1_q    <= wen1_d;
         wen2_q    <= wen2_d;
         ren2_q    <= ren2_d;
         mux_q     <= mux_d;
         rinst_q   <= rinst_d;
         alusrc_q  <= alusrc_d;
         aluop_q   <= aluop_d;
         ill_q     <= ill_d;
      end
   end

   // Branch PC load follows zf directly so the compare result is used in the same cycle.
   assign pcWrite             = pcw_q | ((state_q == S_BRANCH) & zf);
   assign pcSrc               = pcsrc_q;
   assign irWrite             = irw_q;
   assign wEnMemoria1         = wen1_q;
   assign wEnMemoria2         = wen2_q;
   assign rEnMemoria2         = ren2_q;
   assign mux                 = mux_q;
   assign registroInstruccion = rinst_q;
   assign aluSrc              = alusrc_q;
   assign aluOp               = aluop_q;
   assign estado              = state_q;
   assign illegal             = ill_q;
   assign retired             = retired_q;
endmodule
